data_ram: RTL and testbench

//   Data memory on the cpu RAM port. It consumes the ram_EN / ram_RW / ram_address_bus /
//   ram_data_bus_out strobes and returns read data on ram_data_bus_in.

---
 rtl/data_ram.sv | 94 +++++++++
 tb/tb_data_ram.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Word-addressed data memory for the cpu RAM port with a post-reset zero-fill sequencer.
// Read data is registered (1-cycle latency); accesses are ignored until the fill completes.
module data_ram #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_EN,
    input  logic              ram_RW,
    input  logic [ADDR_W-1:0] ram_address_bus,
    input  logic [DATA_W-1:0] ram_data_bus_out,
    output logic [DATA_W-1:0] ram_data_bus_in,
    output logic              ram_ready
);

    localparam int unsigned      DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_next_c;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_next_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              rd_en_c;

    // State, fill pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RESET_STATE;
            clr_addr        <= '0;
            ram_data_bus_in <= '0;
            ram_ready       <= 1'b0;
        end else begin
            state     <= state_next_c;
            clr_addr  <= clr_addr_next_c;
            ram_ready <= (state_next_c == ST_READY);
            if (rd_en_c) begin
                ram_data_bus_in <= mem[ram_address_bus];
            end
        end
    end

    // Next state and array port steering; the fill owns the write port during CLEAR
    always_comb begin
        state_next_c    = state;
        clr_addr_next_c = clr_addr;
        mem_we_c        = 1'b0;
        mem_addr_c      = ram_address_bus;
        mem_wdata_c     = ram_data_bus_out;
        rd_en_c         = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = clr_addr;
                mem_wdata_c = '0;
                if (clr_addr == LAST_ADDR) begin
                    state_next_c = ST_READY;
                end else begin
                    clr_addr_next_c = clr_addr + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (ram_EN) begin
                    rd_en_c  = ram_RW;
                    mem_we_c = !ram_RW;
                end
            end
            default: begin
                state_next_c = RESET_STATE;
            end
        endcase
    end

    // Storage has no reset; it is cleared by the fill sequencer instead
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdata_c;
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram: reset fill, read/write latency,
// boundaries, dropped writes during fill, async reset and read-data hold.
module tb_data_ram;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rw;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic       ready;

    int n_vec = 0;
    int n_err = 0;

    data_ram #(
        .ADDR_W(8),
        .DATA_W(4),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ram_EN(en),
        .ram_RW(rw),
        .ram_address_bus(addr),
        .ram_data_bus_out(wdata),
        .ram_data_bus_in(rdata),
        .ram_ready(ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Release reset and walk the 256 fill edges with whatever cpu inputs are preset
    task automatic fill_phase(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_ready_e%0d", tag, i), {3'b0, ready}, (i == 256) ? 4'h1 : 4'h0);
            check($sformatf("%s_rdata_e%0d", tag, i), rdata, 4'h0);
        end
        en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] d);
        @(negedge clk);
        en = 1'b1; rw = 1'b0; addr = a; wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [3:0] exp);
        @(negedge clk);
        en = 1'b1; rw = 1'b1; addr = a;
        @(posedge clk);
        #1;
        check(tag, rdata, exp);
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rw = 1'b1; addr = '0; wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_ready", {3'b0, ready}, 4'h0);
        check("reset_rdata", rdata, 4'h0);

        // Fill with cpu idle
        fill_phase("t1");

        // Write then read, and an untouched neighbour
        do_write(8'h3C, 4'hA);
        do_read("t2_rd_3c", 8'h3C, 4'hA);
        do_read("t2_rd_3d", 8'h3D, 4'h0);

        // Boundary addresses without aliasing
        do_write(8'h00, 4'h5);
        do_write(8'hFF, 4'hF);
        do_read("t3_rd_00", 8'h00, 4'h5);
        do_read("t3_rd_ff", 8'hFF, 4'hF);
        do_read("t3_rd_01", 8'h01, 4'h0);
        do_read("t3_rd_fe", 8'hFE, 4'h0);

        // Write during fill is dropped
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1; rw = 1'b0; addr = 8'h10; wdata = 4'h7;
        fill_phase("t4");
        do_read("t4_rd_10", 8'h10, 4'h0);

        // Full fill, spot checks, then async reset mid-operation
        for (int a = 0; a < 256; a++) begin
            do_write(8'(a), 4'((a ^ 5) & 4'hF));
        end
        do_read("t5_pre_00", 8'h00, 4'h5);
        do_read("t5_pre_3c", 8'h3C, 4'h9);
        do_read("t5_pre_ff", 8'hFF, 4'hA);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("t5_async_ready", {3'b0, ready}, 4'h0);
        check("t5_async_rdata", rdata, 4'h0);
        fill_phase("t5");
        for (int a = 0; a < 256; a++) begin
            do_read($sformatf("t5_post_%02h", a), 8'(a), 4'h0);
        end

        // Read data holds through idle and writes; back-to-back reads update each cycle
        do_write(8'h20, 4'h3);
        do_write(8'h21, 4'hC);
        do_read("t6_rd_20", 8'h20, 4'h3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6_idle_%0d", i), rdata, 4'h3);
        end
        do_write(8'h21, 4'h9);
        check("t6_after_wr", rdata, 4'h3);
        do_read("t6_b2b_20", 8'h20, 4'h3);
        do_read("t6_b2b_21", 8'h21, 4'h9);
        do_read("t6_b2b_20b", 8'h20, 4'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
